// File: rtl/pc_branch_unit.sv
// Program counter with three link registers, spc/je/jne handling and halt.
// Optional jump/cycle statistics when PC_BRANCH_STATS_EN is defined.
module pc_branch_unit #(
    parameter int PC_W       = 10,
    parameter int SPC_OFFSET = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            JumpEqual,
    input  logic            JumpNotEqual,
    input  logic            OffsetEn,
    input  logic [1:0]      PCRegSelect,
    input  logic            Ack,
    input  logic            Equal,
`ifdef PC_BRANCH_STATS_EN
    output logic [15:0]     TakenCount,
    output logic [15:0]     CycleCount,
`endif
    output logic [PC_W-1:0] ProgCtr,
    output logic            Done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [2:0][PC_W-1:0]   link_q;
    logic [2:0][PC_W-1:0]   link_nxt;
    logic [PC_W-1:0]        pc_nxt;
    logic                   done_nxt;
    logic [PC_W-1:0]        link_sel;
    logic [PC_W-1:0]        save_val;
    logic                   sel_any;
    logic                   jump_cond;
    logic                   taken;
    logic                   save;

    assign sel_any   = (PCRegSelect != 2'b00);
    // JumpEqual dominates when the decoder raises both jump flags.
    assign jump_cond = JumpEqual ? Equal : (JumpNotEqual & ~Equal);
    assign taken     = jump_cond & sel_any;
    assign save      = sel_any & ~JumpEqual & ~JumpNotEqual;
    assign save_val  = ProgCtr + (OffsetEn ? PC_W'(SPC_OFFSET) : PC_W'(1));

    always_comb begin
        link_sel = '0;
        unique case (PCRegSelect)
            2'd1:    link_sel = link_q[0];
            2'd2:    link_sel = link_q[1];
            2'd3:    link_sel = link_q[2];
            default: link_sel = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = ProgCtr;
        link_nxt  = link_q;
        done_nxt  = Done;
        unique case (state)
            IDLE: begin
                pc_nxt   = '0;
                done_nxt = 1'b0;
                if (!Start) state_nxt = RUN;
            end
            RUN: begin
                priority case (1'b1)
                    Start: begin
                        state_nxt = IDLE;
                        pc_nxt    = '0;
                        done_nxt  = 1'b0;
                    end
                    Ack: begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                    taken: pc_nxt = link_sel;
                    default: begin
                        pc_nxt = ProgCtr + PC_W'(1);
                        if (save) begin
                            unique case (PCRegSelect)
                                2'd1:    link_nxt[0] = save_val;
                                2'd2:    link_nxt[1] = save_val;
                                2'd3:    link_nxt[2] = save_val;
                                default: link_nxt    = link_q;
                            endcase
                        end
                    end
                endcase
            end
            DONE: begin
                done_nxt = 1'b1;
                if (Start) begin
                    state_nxt = IDLE;
                    pc_nxt    = '0;
                    done_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = '0;
                done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
            link_q  <= '0;
            Done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ProgCtr <= pc_nxt;
            link_q  <= link_nxt;
            Done    <= done_nxt;
        end
    end

`ifdef PC_BRANCH_STATS_EN
    logic run_jump;
    assign run_jump = (state == RUN) & ~Start & ~Ack & taken;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            TakenCount <= '0;
            CycleCount <= '0;
        end else if (state == IDLE && !Start) begin
            TakenCount <= '0;
            CycleCount <= '0;
        end else if (state == RUN) begin
            if (CycleCount != 16'hFFFF) CycleCount <= CycleCount + 16'd1;
            if (run_jump && TakenCount != 16'hFFFF)
                TakenCount <= TakenCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: reset, spc/je/jne, wrap, halt, restart.
module tb_pc_branch_unit;

    localparam int PC_W = 10;

    logic            Clk = 1'b0;
    logic            Reset, Start;
    logic            JumpEqual, JumpNotEqual, OffsetEn;
    logic [1:0]      PCRegSelect;
    logic            Ack, Equal;
    logic [PC_W-1:0] ProgCtr;
    logic            Done;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0]     TakenCount, CycleCount;
    logic [15:0]     tc_hold, cc_hold;
`endif

    int checks   = 0;
    int failures = 0;

    pc_branch_unit #(.PC_W(PC_W), .SPC_OFFSET(2)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Start(Start),
        .JumpEqual(JumpEqual),
        .JumpNotEqual(JumpNotEqual),
        .OffsetEn(OffsetEn),
        .PCRegSelect(PCRegSelect),
        .Ack(Ack),
        .Equal(Equal),
`ifdef PC_BRANCH_STATS_EN
        .TakenCount(TakenCount),
        .CycleCount(CycleCount),
`endif
        .ProgCtr(ProgCtr),
        .Done(Done)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drv(input logic je, input logic jne, input logic off,
                       input logic [1:0] sel, input logic eq,
                       input logic ack);
        JumpEqual    = je;
        JumpNotEqual = jne;
        OffsetEn     = off;
        PCRegSelect  = sel;
        Equal        = eq;
        Ack          = ack;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        drv(0, 0, 0, 2'd0, 0, 0);
        step();
        step();
        checks++;
        if (ProgCtr !== 10'd0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset pc=%0d done=%0b exp pc=0 done=0",
                     ProgCtr, Done);
        end
        Reset = 1'b0;
        Start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (ProgCtr !== 10'd0) begin
                failures++;
                $display("FAIL start_hold pc=%0d exp=0", ProgCtr);
            end
        end
        Start = 1'b0;
        step();
        checks++;
        if (ProgCtr !== 10'd0) begin
            failures++;
            $display("FAIL first_run pc=%0d exp=0", ProgCtr);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if (ProgCtr !== PC_W'(i) || Done !== 1'b0) begin
                failures++;
                $display("FAIL count pc=%0d done=%0b exp pc=%0d done=0",
                         ProgCtr, Done, i);
            end
        end
    endtask

    task automatic test_spc();
        step();
        step();
        drv(0, 0, 0, 2'd2, 0, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd6) begin
            failures++;
            $display("FAIL spc2 pc=%0d exp=6", ProgCtr);
        end
        drv(0, 0, 0, 2'd0, 0, 0);
        step();
        drv(0, 0, 1, 2'd1, 0, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd8) begin
            failures++;
            $display("FAIL spc1_off pc=%0d exp=8", ProgCtr);
        end
        drv(0, 0, 0, 2'd0, 0, 0);
        repeat (4) step();
        checks++;
        if (ProgCtr !== 10'd12) begin
            failures++;
            $display("FAIL run_to_12 pc=%0d exp=12", ProgCtr);
        end
    endtask

    task automatic test_jumps();
        drv(1, 0, 0, 2'd0, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd13) begin
            failures++;
            $display("FAIL je_sel0 pc=%0d exp=13", ProgCtr);
        end
        drv(0, 1, 0, 2'd1, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd14) begin
            failures++;
            $display("FAIL jne_nt pc=%0d exp=14", ProgCtr);
        end
        drv(0, 1, 0, 2'd1, 0, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd9) begin
            failures++;
            $display("FAIL jne_t pc=%0d exp=9", ProgCtr);
        end
        drv(1, 0, 0, 2'd2, 0, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd10) begin
            failures++;
            $display("FAIL je_nt pc=%0d exp=10", ProgCtr);
        end
        drv(0, 0, 0, 2'd0, 0, 0);
        repeat (10) step();
        drv(1, 0, 0, 2'd2, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd6) begin
            failures++;
            $display("FAIL je_t pc=%0d exp=6", ProgCtr);
        end
        drv(0, 0, 0, 2'd0, 0, 0);
        repeat (32) step();
        drv(0, 0, 1, 2'd3, 0, 0);
        step();
        drv(1, 1, 0, 2'd3, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd40) begin
            failures++;
            $display("FAIL both_t pc=%0d exp=40", ProgCtr);
        end
        drv(1, 1, 0, 2'd3, 0, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd41) begin
            failures++;
            $display("FAIL both_je_wins pc=%0d exp=41", ProgCtr);
        end
        drv(0, 0, 0, 2'd1, 0, 0);
        step();
        drv(1, 0, 0, 2'd1, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd42) begin
            failures++;
            $display("FAIL save_fwd pc=%0d exp=42", ProgCtr);
        end
    endtask

    task automatic test_wrap();
        drv(0, 0, 0, 2'd0, 0, 0);
        repeat (981) step();
        checks++;
        if (ProgCtr !== 10'd1023) begin
            failures++;
            $display("FAIL run_to_top pc=%0d exp=1023", ProgCtr);
        end
        drv(0, 0, 1, 2'd3, 0, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd0) begin
            failures++;
            $display("FAIL wrap pc=%0d exp=0", ProgCtr);
        end
        drv(0, 0, 0, 2'd0, 0, 0);
        repeat (5) step();
        drv(1, 0, 0, 2'd3, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd1) begin
            failures++;
            $display("FAIL wrap_save pc=%0d exp=1", ProgCtr);
        end
    endtask

    task automatic test_halt();
        drv(0, 0, 0, 2'd0, 0, 0);
        repeat (29) step();
        drv(1, 0, 0, 2'd2, 1, 1);
        step();
        checks++;
        if (ProgCtr !== 10'd30 || Done !== 1'b1) begin
            failures++;
            $display("FAIL ack pc=%0d done=%0b exp pc=30 done=1",
                     ProgCtr, Done);
        end
`ifdef PC_BRANCH_STATS_EN
        tc_hold = TakenCount;
        cc_hold = CycleCount;
`endif
        for (int i = 0; i < 5; i++) begin
            drv(~i[0], i[0], i[1], 2'd2, i[0] ^ i[1], 0);
            step();
            checks++;
            if (ProgCtr !== 10'd30 || Done !== 1'b1) begin
                failures++;
                $display("FAIL frozen pc=%0d done=%0b exp pc=30 done=1",
                         ProgCtr, Done);
            end
        end
`ifdef PC_BRANCH_STATS_EN
        checks++;
        if (TakenCount !== tc_hold || CycleCount !== cc_hold) begin
            failures++;
            $display("FAIL stats_hold tc=%0d cc=%0d exp tc=%0d cc=%0d",
                     TakenCount, CycleCount, tc_hold, cc_hold);
        end
`endif
        drv(0, 0, 0, 2'd0, 0, 0);
        Start = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 10'd0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL restart pc=%0d done=%0b exp pc=0 done=0",
                     ProgCtr, Done);
        end
        Start = 1'b0;
        step();
`ifdef PC_BRANCH_STATS_EN
        checks++;
        if (TakenCount !== 16'd0 || CycleCount !== 16'd0) begin
            failures++;
            $display("FAIL stats_clear tc=%0d cc=%0d exp 0 0",
                     TakenCount, CycleCount);
        end
`endif
        step();
        step();
        checks++;
        if (ProgCtr !== 10'd2) begin
            failures++;
            $display("FAIL rerun pc=%0d exp=2", ProgCtr);
        end
    endtask

    task automatic test_back_to_run();
        Start = 1'b1;
        step();
        checks++;
        if (ProgCtr !== 10'd0) begin
            failures++;
            $display("FAIL run_start pc=%0d exp=0", ProgCtr);
        end
        Start = 1'b0;
        step();
        drv(1, 0, 0, 2'd1, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd42 || Done !== 1'b0) begin
            failures++;
            $display("FAIL links_kept pc=%0d done=%0b exp pc=42 done=0",
                     ProgCtr, Done);
        end
        drv(0, 0, 0, 2'd0, 0, 0);
        step();
        Reset = 1'b1;
        drv(1, 0, 0, 2'd1, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset pc=%0d done=%0b exp pc=0 done=0",
                     ProgCtr, Done);
        end
        Reset = 1'b0;
        drv(0, 0, 0, 2'd0, 0, 0);
        step();
        step();
        drv(1, 0, 0, 2'd1, 1, 0);
        step();
        checks++;
        if (ProgCtr !== 10'd0) begin
            failures++;
            $display("FAIL links_cleared pc=%0d exp=0", ProgCtr);
        end
    endtask

    initial begin
        test_reset();
        test_spc();
        test_jumps();
        test_wrap();
        test_halt();
        test_back_to_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
